ft245_fifo_responder: RTL

FT245_FIFO_RESPONDER -- requirements
Module: ft245_fifo_responder

---
 rtl/ft245_pkg.sv | 21 ++
 rtl/ft245_sync_fifo.sv | 40 ++++
 rtl/ft245_fifo_responder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ft245_pkg.sv
`default_nettype none
// ft245_pkg: shared state encoding and strobe pulse-width limits for the FT245 responder.
package ft245_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } ft245_state_e;

  localparam int unsigned MIN_LOW_PULSE = 4;
  localparam int unsigned MIN_HIGH_GAP  = 6;
  localparam int unsigned PULSE_CNT_W   = 3;

  // Saturating increment so long idle periods never wrap back into "too short".
  function automatic logic [PULSE_CNT_W-1:0] sat_inc(input logic [PULSE_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ft245_sync_fifo.sv
`default_nettype none
// ft245_sync_fifo: byte-wide synchronous FIFO, extra pointer MSB distinguishes full from empty.
module ft245_sync_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  logic [7:0]  mem_q [DEPTH];

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o)  wptr_q <= wptr_q + 1'b1;
      if (pop_i  && !empty_o) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/ft245_fifo_responder.sv
`default_nettype none
// ft245_fifo_responder: FT245-style RX/TX FIFO bridge between a strobe master and a valid/ready host.
// Define FT245_TIMING_CHECK_EN to flag RD/WR pulses or gaps that are too short on ERR.
module ft245_fifo_responder
  import ft245_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FLAG_HOLD = 4
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       RD,
  input  logic       WR,
  inout  wire  [7:0] USBX,
  output logic       RXF,
  output logic       TXE,
  input  logic [7:0] H_WDATA,
  input  logic       H_WVALID,
  output logic       H_WREADY,
  output logic [7:0] H_RDATA,
  output logic       H_RVALID,
  input  logic       H_RREADY,
  output logic       ERR
);
  localparam int unsigned       HOLD_W    = (FLAG_HOLD > 2) ? $clog2(FLAG_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FLAG_HOLD - 1);

  logic              rd_q, wr_q;
  ft245_state_e      rd_st_q, wr_st_q;
  logic [HOLD_W-1:0] rd_hold_q, wr_hold_q;
  logic [7:0]        rd_data_q;
  logic              rd_valid_q;
  logic              err_q;

  logic       rd_fall, rd_rise, wr_fall, wr_rise;
  logic       rd_start, wr_start;
  logic       rx_push, rx_pop, tx_push, tx_pop;
  logic       rx_empty, rx_full, tx_empty, tx_full;
  logic [7:0] rx_head;
  logic       timing_err;
  logic       err_set;

  ft245_sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk_i   (CLK),
    .rst_ni  (RSTN),
    .push_i  (rx_push),
    .data_i  (H_WDATA),
    .pop_i   (rx_pop),
    .data_o  (rx_head),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  ft245_sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk_i   (CLK),
    .rst_ni  (RSTN),
    .push_i  (tx_push),
    .data_i  (USBX),
    .pop_i   (tx_pop),
    .data_o  (H_RDATA),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  assign rd_fall  = rd_q & ~RD;
  assign rd_rise  = ~rd_q & RD;
  assign wr_fall  = wr_q & ~WR;
  assign wr_rise  = ~wr_q & WR;
  assign rd_start = rd_fall & (rd_st_q != ACTIVE);
  assign wr_start = wr_fall & (wr_st_q != ACTIVE);

  assign rx_push = H_WVALID & ~rx_full;
  assign rx_pop  = rd_rise & (rd_st_q == ACTIVE) & rd_valid_q;
  assign tx_push = wr_start & ~tx_full;
  assign tx_pop  = H_RVALID & H_RREADY;

  assign err_set = (rd_start & (rx_empty | (rd_st_q == HOLD)))
                 | (wr_start & (tx_full  | (wr_st_q == HOLD)))
                 | timing_err;

  assign USBX     = (rd_st_q == ACTIVE && !RD) ? rd_data_q : 8'hzz;
  assign RXF      = ~(~rx_empty & RD & (rd_st_q == IDLE));
  assign TXE      = ~(~tx_full & (wr_st_q == IDLE));
  assign H_WREADY = ~rx_full;
  assign H_RVALID = ~tx_empty;
  assign ERR      = err_q;

  // Strobe registers reset low so a strobe held low through reset produces no falling edge.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      rd_st_q    <= IDLE;
      wr_st_q    <= IDLE;
      rd_hold_q  <= '0;
      wr_hold_q  <= '0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_q <= RD;
      wr_q <= WR;
      if (err_set) err_q <= 1'b1;

      if (rd_start) begin
        rd_st_q    <= ACTIVE;
        rd_data_q  <= rx_empty ? 8'h00 : rx_head;
        rd_valid_q <= ~rx_empty;
      end else begin
        case (rd_st_q)
          ACTIVE: if (rd_rise) begin
            rd_st_q   <= HOLD;
            rd_hold_q <= HOLD_LOAD;
          end
          HOLD: if (rd_hold_q == '0) rd_st_q <= IDLE;
                else rd_hold_q <= rd_hold_q - 1'b1;
          default: rd_st_q <= IDLE;
        endcase
      end

      if (wr_start) begin
        wr_st_q <= ACTIVE;
      end else begin
        case (wr_st_q)
          ACTIVE: if (wr_rise) begin
            wr_st_q   <= HOLD;
            wr_hold_q <= HOLD_LOAD;
          end
          HOLD: if (wr_hold_q == '0) wr_st_q <= IDLE;
                else wr_hold_q <= wr_hold_q - 1'b1;
          default: wr_st_q <= IDLE;
        endcase
      end
    end
  end

`ifdef FT245_TIMING_CHECK_EN
  localparam logic [PULSE_CNT_W-1:0] ONE_C  = PULSE_CNT_W'(1);
  localparam logic [PULSE_CNT_W-1:0] MIN_LO = PULSE_CNT_W'(MIN_LOW_PULSE);
  localparam logic [PULSE_CNT_W-1:0] MIN_HI = PULSE_CNT_W'(MIN_HIGH_GAP);

  logic [PULSE_CNT_W-1:0] rd_lo_q, rd_hi_q, wr_lo_q, wr_hi_q;

  // Counters hold the length of the current level; reset saturated so nothing is flagged at start-up.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      rd_lo_q <= '1;
      rd_hi_q <= '1;
      wr_lo_q <= '1;
      wr_hi_q <= '1;
    end else begin
      rd_lo_q <= rd_fall ? ONE_C : (!RD ? sat_inc(rd_lo_q) : rd_lo_q);
      rd_hi_q <= rd_rise ? ONE_C : ( RD ? sat_inc(rd_hi_q) : rd_hi_q);
      wr_lo_q <= wr_fall ? ONE_C : (!WR ? sat_inc(wr_lo_q) : wr_lo_q);
      wr_hi_q <= wr_rise ? ONE_C : ( WR ? sat_inc(wr_hi_q) : wr_hi_q);
    end
  end

  assign timing_err = (rd_rise && (rd_lo_q < MIN_LO)) || (rd_fall && (rd_hi_q < MIN_HI))
                   || (wr_rise && (wr_lo_q < MIN_LO)) || (wr_fall && (wr_hi_q < MIN_HI));
`else
  assign timing_err = 1'b0;
`endif

endmodule
`default_nettype wire
